// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipe_stage_reg elastic pipeline register chain.
// Holds the statistics counter width, the occupancy width helper and the
// parameter legality check used by the top module at elaboration time.
package pipe_stage_reg_pkg;

  // Width of the optional transfer / backpressure statistics counters.
  localparam int STAT_W = 32;

  // Bits needed to count 0..stages valid slots.
  function automatic int OCC_W(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Legal configurations: at least one payload bit and at least one slot.
  function automatic bit pipe_params_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the pipeline chain: a valid bit plus a payload word.
// The payload only loads when a valid item arrives, so the data of an empty
// slot keeps whatever it last carried (the output data holds while empty).
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clr,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid bit: clear wins over load; on load it copies the upstream valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
    end
  end

  // Payload: captured only when a valid item moves in; never cleared by clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (load && src_valid && !clr) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised elastic pipeline register chain with valid/ready handshake,
// bubble collapsing, stall (freeze) and flush (invalidate all slots).
// Optional statistics counters are built when PIPE_STAGE_REG_STATS_EN is
// defined; the default build omits those ports and their logic.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      stall,
  input  logic                      flush,
  output logic [OCC_W(STAGES)-1:0]  occupancy
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_xfers,
  output logic [STAT_W-1:0]         stat_bp
`endif
);

  localparam int OW = OCC_W(STAGES);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  // Reject illegal configurations while elaborating.
  if (!pipe_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_stage_reg: WIDTH and STAGES must both be at least 1");
  end

  logic [STAGES-1:0]            slot_valid;
  logic [STAGES-1:0][WIDTH-1:0] slot_data;
  logic [STAGES-1:0]            rdy;
  logic                         advance;
  logic                         in_xfer;
  logic                         out_xfer;
  logic [OW-1:0]                occ_reg;
  logic [OW-1:0]                occ_next;

  // Transfers happen only when neither freeze nor clear is requested.
  assign advance = !stall && !flush;

  // Ready chain: a slot can take new contents if it is empty or its
  // occupant moves on this cycle, which lets items close up bubbles.
  assign rdy[STAGES-1] = !slot_valid[STAGES-1] || out_ready;

  genvar gi;
  for (gi = 0; gi < STAGES - 1; gi++) begin : g_rdy
    assign rdy[gi] = !slot_valid[gi] || rdy[gi+1];
  end

  // Upstream handshake; held low while reset is asserted.
  assign in_ready = reset_n && rdy[0] && advance;
  assign in_xfer  = in_valid && in_ready;

  // Downstream handshake straight from the last slot's registers.
  assign out_valid = slot_valid[STAGES-1] && advance;
  assign out_data  = slot_data[STAGES-1];
  assign out_xfer  = out_valid && out_ready;

  // Slot array: slot 0 faces the input, slot STAGES-1 faces the output.
  for (gi = 0; gi < STAGES; gi++) begin : g_slot
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (gi == 0) begin : g_head
      assign src_valid = in_xfer;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = slot_valid[gi-1];
      assign src_data  = slot_data[gi-1];
    end

    pipe_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (rdy[gi] && advance),
      .clr       (flush),
      .src_valid (src_valid),
      .src_data  (src_data),
      .valid     (slot_valid[gi]),
      .data      (slot_data[gi])
    );
  end

  // Occupancy next value: flush empties, a lone input or output moves by one.
  always_comb begin
    occ_next = occ_reg;
    if (flush) begin
      occ_next = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_next = occ_reg + OCC_ONE;
    end else if (!in_xfer && out_xfer) begin
      occ_next = occ_reg - OCC_ONE;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign occupancy = occ_reg;

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [STAT_W-1:0] stat_xfers_reg;
  logic [STAT_W-1:0] stat_bp_reg;
  logic              bp_cycle;

  // Backpressure: the output holds an item the consumer refuses.
  assign bp_cycle = slot_valid[STAGES-1] && !out_ready && advance;

  // Saturating statistics counters; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_xfers_reg <= '0;
      stat_bp_reg    <= '0;
    end else begin
      if (out_xfer && !(&stat_xfers_reg)) begin
        stat_xfers_reg <= stat_xfers_reg + STAT_W'(1);
      end
      if (bp_cycle && !(&stat_bp_reg)) begin
        stat_bp_reg <= stat_bp_reg + STAT_W'(1);
      end
    end
  end

  assign stat_xfers = stat_xfers_reg;
  assign stat_bp    = stat_bp_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (WIDTH=32, STAGES=3). A queue of
// in-flight items, each tagged with its slot position, serves as reference.
// Build with PIPE_STAGE_REG_STATS_EN defined to also check the statistics.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int OW     = OCC_W(STAGES);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             stall;
  logic             flush;
  logic [OW-1:0]    occupancy;
`ifdef PIPE_STAGE_REG_STATS_EN
  logic [STAT_W-1:0] stat_xfers;
  logic [STAT_W-1:0] stat_bp;
`endif

  pipe_stage_reg #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    .stat_xfers (stat_xfers),
    .stat_bp    (stat_bp)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: items in order (oldest first) with slot positions.
  int               pos_q[$];
  logic [WIDTH-1:0] dat_q[$];
  int               exp_xfers = 0;
  int               exp_bp    = 0;
  logic [WIDTH-1:0] last_out  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                     input bit st, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  // One clock: compare outputs at the falling edge, advance the model,
  // then return just after the rising edge so new inputs can be driven.
  task automatic step();
    int               n;
    bit               mv[STAGES];
    bit               exp_ir;
    bit               exp_ov;
    int               np[$];
    logic [WIDTH-1:0] nd[$];
    @(negedge clk);
    n = pos_q.size();
    for (int k = 0; k < n && k < STAGES; k++) begin
      if (k == 0) mv[k] = (pos_q[0] == STAGES - 1) ? out_ready : 1'b1;
      else        mv[k] = (pos_q[k] + 1 != pos_q[k-1]) || mv[k-1];
    end
    exp_ov = !stall && !flush && n > 0 && pos_q[0] == STAGES - 1;
    exp_ir = !stall && !flush && (n == 0 || pos_q[n-1] != 0 || mv[n-1]);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    check("occupancy", occupancy, n);
    if (exp_ov) check("out_data", out_data, dat_q[0]);
`ifdef PIPE_STAGE_REG_STATS_EN
    check("stat_xfers", stat_xfers, exp_xfers);
    check("stat_bp", stat_bp, exp_bp);
`endif
    if (flush) begin
      pos_q.delete();
      dat_q.delete();
    end else if (!stall) begin
      if (exp_ov && !out_ready) exp_bp++;
      for (int k = 0; k < n && k < STAGES; k++) begin
        if (k == 0 && pos_q[0] == STAGES - 1) begin
          if (out_ready) begin
            exp_xfers++;
            last_out = dat_q[0];
          end else begin
            np.push_back(pos_q[0]);
            nd.push_back(dat_q[0]);
          end
        end else begin
          np.push_back(pos_q[k] + (mv[k] ? 1 : 0));
          nd.push_back(dat_q[k]);
        end
      end
      if (in_valid && exp_ir) begin
        np.push_back(0);
        nd.push_back(in_data);
      end
      pos_q = np;
      dat_q = nd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drv(0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with the consumer always ready.
    for (int i = 1; i <= 4; i++) begin
      drv(1, WIDTH'(i), 1, 0, 0);
      step();
    end
    drv(0, '0, 1, 0, 0);
    repeat (5) step();
    check("empty_hold", out_data, 32'h4);

    // Backpressure until full, then a simultaneous in/out transfer.
    drv(1, 32'hA, 0, 0, 0); step();
    drv(1, 32'hB, 0, 0, 0); step();
    drv(1, 32'hC, 0, 0, 0); step();
    drv(1, 32'hD, 0, 0, 0); step();
    drv(1, 32'hD, 1, 0, 0); step();
    drv(0, '0, 1, 0, 0);
    repeat (5) step();

    // Bubble collapse under backpressure.
    drv(1, 32'h11, 0, 0, 0); step();
    drv(0, '0, 0, 0, 0); repeat (2) step();
    drv(1, 32'h22, 0, 0, 0); step();
    drv(0, '0, 0, 0, 0); repeat (2) step();
    drv(0, '0, 1, 0, 0); repeat (3) step();

    // Stall with two items held.
    drv(1, 32'h5, 0, 0, 0); step();
    drv(1, 32'h6, 0, 0, 0); step();
    drv(1, 32'h7, 1, 1, 0); repeat (4) step();
    drv(0, '0, 1, 0, 0); repeat (5) step();

    // Flush together with stall while full.
    drv(1, 32'h31, 0, 0, 0); step();
    drv(1, 32'h32, 0, 0, 0); step();
    drv(1, 32'h33, 0, 0, 0); step();
    drv(1, 32'h99, 1, 1, 1); step();
    drv(1, 32'h77, 1, 0, 0); step();
    drv(0, '0, 1, 0, 0); repeat (4) step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      drv($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      step();
    end

    // Asynchronous reset between clock edges with the chain full.
    drv(0, '0, 1, 0, 1); step();
    drv(1, 32'h41, 0, 0, 0); step();
    drv(1, 32'h42, 0, 0, 0); step();
    drv(1, 32'h43, 0, 0, 0); step();
    drv(0, '0, 0, 0, 0); step();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_occupancy", occupancy, 0);
    check("arst_in_ready", in_ready, 0);
`ifdef PIPE_STAGE_REG_STATS_EN
    check("arst_stat_xfers", stat_xfers, 0);
    check("arst_stat_bp", stat_bp, 0);
`endif
    pos_q.delete();
    dat_q.delete();
    exp_xfers = 0;
    exp_bp    = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Traffic resumes cleanly after reset.
    drv(1, 32'h55, 1, 0, 0); step();
    drv(0, '0, 1, 0, 0); repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
